store_buffer: RTL

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/storebuf_pkg.sv | 13 +
 rtl/sb_fifo.sv | 59 +++++
 rtl/store_buffer.sv | 99 +++++++++
 3 files changed

// File: rtl/storebuf_pkg.sv
// Shared types and sizing for the store buffer.
// Optional load forwarding is enabled by STOREBUF_FWD_EN.
package storebuf_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_PTR_W = $clog2(SB_DEPTH);

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// Store buffer storage: circular FIFO with occupancy count.
// With STOREBUF_FWD_EN the raw entries are exposed for forwarding.
import storebuf_pkg::*;

module sb_fifo #(
  parameter int DEPTH = SB_DEPTH,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  sb_entry_t               i_entry,
  output sb_entry_t               o_head,
  output logic [CW-1:0]           o_count,
`ifdef STOREBUF_FWD_EN
  output logic [PW-1:0]           o_rptr,
  output sb_entry_t [DEPTH-1:0]   o_entries,
`endif
  output logic                    o_empty
);

  sb_entry_t [DEPTH-1:0] r_mem;
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;

  // DEPTH is a power of two, so pointers wrap by plain overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_entry;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

`ifdef STOREBUF_FWD_EN
  assign o_rptr    = r_rptr;
  assign o_entries = r_mem;
`endif

endmodule

// File: rtl/store_buffer.sv
// Write-back store buffer between core and memory.
// STOREBUF_FWD_EN: forward loads from buffered stores instead of stalling.
import storebuf_pkg::*;

module store_buffer #(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         MemWrite,
  input  logic                         MemRead,
  input  logic [31:0]                  DataAdr,
  input  logic [31:0]                  WriteData,
  output logic [31:0]                  ReadData,
  output logic                         Stall,
  output logic                         mem_req,
  output logic [31:0]                  mem_addr,
  output logic [31:0]                  mem_wdata,
  input  logic                         mem_ack,
  output logic [31:0]                  mem_raddr,
  input  logic [31:0]                  mem_rdata,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  sb_entry_t w_head;
  sb_entry_t w_new;
  logic      w_push;
  logic      w_pop;
  logic      w_full;
  logic      w_unused_adr;

  assign w_unused_adr = &{1'b0, DataAdr[1:0]};

  assign w_new  = '{addr: DataAdr[31:2], data: WriteData};
  assign w_full = (count == CW'(DEPTH));
  // A full buffer never accepts a store, even if the head drains now
  assign w_push = MemWrite & ~Stall;
  assign w_pop  = mem_req & mem_ack;

`ifdef STOREBUF_FWD_EN
  logic [PW-1:0]         w_rptr;
  sb_entry_t [DEPTH-1:0] w_ents;
  logic [PW-1:0]         w_idx;
  logic                  w_hit;
  logic [31:0]           w_fwd;
`endif

  sb_fifo #(
    .DEPTH (DEPTH),
    .PW    (PW),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_entry   (w_new),
    .o_head    (w_head),
    .o_count   (count),
`ifdef STOREBUF_FWD_EN
    .o_rptr    (w_rptr),
    .o_entries (w_ents),
`endif
    .o_empty   (empty)
  );

  assign mem_req   = ~empty;
  assign mem_addr  = {w_head.addr, 2'b00};
  assign mem_wdata = w_head.data;
  assign mem_raddr = {DataAdr[31:2], 2'b00};

`ifdef STOREBUF_FWD_EN
  // Scan oldest to youngest so the last hit is the youngest match
  always_comb begin
    w_hit = 1'b0;
    w_fwd = '0;
    w_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = w_rptr + PW'(i);
      if ((CW'(i) < count) &&
          (w_ents[w_idx].addr == DataAdr[31:2])) begin
        w_hit = 1'b1;
        w_fwd = w_ents[w_idx].data;
      end
    end
  end

  assign Stall    = MemWrite & w_full;
  assign ReadData = (MemRead & w_hit) ? w_fwd : mem_rdata;
`else
  assign Stall    = (MemWrite & w_full) | (MemRead & ~empty);
  assign ReadData = mem_rdata;
`endif

endmodule
